// File: rtl/npc_pkg.sv
// Shared NPC core definitions: opcodes, funct3 codes, ALU codes and the
// decoded instruction bundle passed from decode to execute.
package npc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned REG_W  = 5;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLTIU = 3'b011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_LUI  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_JAL  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_JALR = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLTU = 3'b100;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } idu_buf_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [ALU_W-1:0]  alu_ctrl;
    logic [DATA_W-1:0] imm;
    logic              src1_sel;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rd;
    logic              wen;
    logic              jump;
    logic              ebreak;
    logic              illegal;
  } idu_bundle_t;

endpackage

// File: rtl/idu_stage_if.sv
// Fetch-side and execute-side handshake signals of the decode stage.
interface idu_stage_if #(parameter int unsigned XLEN = 32);
  import npc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [ALU_W-1:0]  out_alu_ctrl;
  logic [XLEN-1:0]   out_imm;
  logic              out_src1_sel;
  logic [REG_W-1:0]  out_rs1;
  logic [REG_W-1:0]  out_rd;
  logic              out_wen;
  logic              out_jump;
  logic              out_ebreak;
  logic              out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_ctrl, out_imm, out_src1_sel,
           out_rs1, out_rd, out_wen, out_jump, out_ebreak, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_alu_ctrl, out_imm, out_src1_sel,
           out_rs1, out_rd, out_wen, out_jump, out_ebreak, out_illegal
  );
endinterface

// File: rtl/idu_decode.sv
// Combinational RV32 decoder: raw instruction + PC into the ALU control bundle.
module idu_decode
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output idu_bundle_t     o_bundle_c
);

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [DATA_W-1:0] w_imm_i;
  logic [DATA_W-1:0] w_imm_u;
  logic [DATA_W-1:0] w_imm_j;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_u  = {i_inst[31:12], 12'b0};
  assign w_imm_j  = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // Illegal encodings keep ctrl/imm at zero and only raise the illegal flag.
  always_comb begin
    o_bundle_c     = '0;
    o_bundle_c.pc  = DATA_W'(i_pc);
    o_bundle_c.rs1 = i_inst[19:15];
    o_bundle_c.rd  = i_inst[11:7];
    if (i_inst == INST_EBREAK) begin
      o_bundle_c.ebreak = 1'b1;
    end else begin
      o_bundle_c.wen = 1'b1;
      case (w_opcode)
        OP_LUI: begin
          o_bundle_c.alu_ctrl = ALU_LUI;
          o_bundle_c.imm      = w_imm_u;
        end
        OP_AUIPC: begin
          o_bundle_c.alu_ctrl = ALU_ADD;
          o_bundle_c.src1_sel = 1'b1;
          o_bundle_c.imm      = w_imm_u;
        end
        OP_JAL: begin
          o_bundle_c.alu_ctrl = ALU_JAL;
          o_bundle_c.src1_sel = 1'b1;
          o_bundle_c.imm      = w_imm_j;
          o_bundle_c.jump     = 1'b1;
        end
        OP_JALR: begin
          if (w_funct3 == F3_JALR) begin
            o_bundle_c.alu_ctrl = ALU_JALR;
            o_bundle_c.imm      = w_imm_i;
            o_bundle_c.jump     = 1'b1;
          end else begin
            o_bundle_c.wen     = 1'b0;
            o_bundle_c.illegal = 1'b1;
          end
        end
        OP_IMM: begin
          case (w_funct3)
            F3_ADDI: begin
              o_bundle_c.alu_ctrl = ALU_ADD;
              o_bundle_c.imm      = w_imm_i;
            end
            F3_SLTIU: begin
              o_bundle_c.alu_ctrl = ALU_SLTU;
              o_bundle_c.imm      = w_imm_i;
            end
            default: begin
              o_bundle_c.wen     = 1'b0;
              o_bundle_c.illegal = 1'b1;
            end
          endcase
        end
        default: begin
          o_bundle_c.wen     = 1'b0;
          o_bundle_c.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/idu_stage.sv
// NPC instruction decode stage: decodes at the input and holds results in a
// two-entry skid buffer so execute-side ready never reaches fetch combinationally.
module idu_stage
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  idu_stage_if.slave  bus
);

  idu_buf_state_e  r_state;
  idu_buf_state_e  w_state_nxt;
  idu_bundle_t     w_dec;
  idu_bundle_t     r_ent0;
  idu_bundle_t     r_ent1;
  idu_bundle_t     w_ent0_nxt;
  idu_bundle_t     w_ent1_nxt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            w_in_fire;
  logic            w_out_fire;
  logic [XLEN-1:0] w_in_pc;

  assign w_in_pc = bus.in_pc;

  idu_decode #(.XLEN(XLEN)) u_decode (
    .i_inst     (bus.in_inst),
    .i_pc       (w_in_pc),
    .o_bundle_c (w_dec)
  );

  // A flushed input is never taken, even if the stage was ready.
  assign w_in_fire  = bus.in_valid & r_in_ready & ~flush;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // r_ent0 is always the oldest entry and drives the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ent0_nxt  = r_ent0;
    w_ent1_nxt  = r_ent1;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_ent0_nxt  = w_dec;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b11: w_ent0_nxt = w_dec;
          2'b10: begin
            w_ent1_nxt  = w_dec;
            w_state_nxt = S_FULL;
          end
          2'b01: w_state_nxt = S_EMPTY;
          default: begin
          end
        endcase
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_ent0_nxt  = r_ent1;
          w_state_nxt = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_ent0_nxt  = '0;
      w_ent1_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_ent0      <= '0;
      r_ent1      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ent0      <= w_ent0_nxt;
      r_ent1      <= w_ent1_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_pc       = XLEN'(r_ent0.pc);
  assign bus.out_alu_ctrl = r_ent0.alu_ctrl;
  assign bus.out_imm      = XLEN'(r_ent0.imm);
  assign bus.out_src1_sel = r_ent0.src1_sel;
  assign bus.out_rs1      = r_ent0.rs1;
  assign bus.out_rd       = r_ent0.rd;
  assign bus.out_wen      = r_ent0.wen;
  assign bus.out_jump     = r_ent0.jump;
  assign bus.out_ebreak   = r_ent0.ebreak;
  assign bus.out_illegal  = r_ent0.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: directed decode/backpressure/flush/reset cases plus a
// randomized phase, all checked by a scoreboard fed from a reference decoder.
module tb_idu_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  ctrl;
    logic [31:0] imm;
    logic        src1;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        wen;
    logic        jump;
    logic        ebreak;
    logic        illegal;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;

  idu_stage_if bus ();

  idu_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] ctrl,
                              input logic [31:0] imm, input logic src1,
                              input logic [4:0] rs1, input logic [4:0] rd,
                              input logic wen, input logic jump,
                              input logic ebreak, input logic illegal);
    exp_t e;
    e = '{pc: pc, ctrl: ctrl, imm: imm, src1: src1, rs1: rs1, rd: rd,
          wen: wen, jump: jump, ebreak: ebreak, illegal: illegal};
    return e;
  endfunction

  // Reference decoder: immediates computed as signed integers from the field layouts.
  function automatic exp_t ref_dec(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int   ival;
    int   jval;
    logic [20:0] jbits;
    e     = '0;
    e.pc  = pc;
    e.rs1 = inst[19:15];
    e.rd  = inst[11:7];
    ival  = int'(inst[31:20]);
    if (inst[31]) ival = ival - 4096;
    jbits = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    jval  = int'(jbits);
    if (inst[31]) jval = jval - (1 << 21);
    if (inst == 32'h0010_0073) begin
      e.ebreak = 1'b1;
      return e;
    end
    e.wen = 1'b1;
    case (inst[6:0])
      7'b0110111: begin e.ctrl = 3'd1; e.imm = {inst[31:12], 12'h000}; end
      7'b0010111: begin e.ctrl = 3'd0; e.imm = {inst[31:12], 12'h000}; e.src1 = 1'b1; end
      7'b1101111: begin e.ctrl = 3'd2; e.imm = 32'(jval); e.src1 = 1'b1; e.jump = 1'b1; end
      7'b1100111: begin
        if (inst[14:12] == 3'd0) begin e.ctrl = 3'd3; e.imm = 32'(ival); e.jump = 1'b1; end
        else begin e.wen = 1'b0; e.illegal = 1'b1; end
      end
      7'b0010011: begin
        if (inst[14:12] == 3'd0)      begin e.ctrl = 3'd0; e.imm = 32'(ival); end
        else if (inst[14:12] == 3'd3) begin e.ctrl = 3'd4; e.imm = 32'(ival); end
        else begin e.wen = 1'b0; e.illegal = 1'b1; end
      end
      default: begin e.wen = 1'b0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic exp_t act_bundle();
    exp_t a;
    a = '{pc: bus.out_pc, ctrl: bus.out_alu_ctrl, imm: bus.out_imm,
          src1: bus.out_src1_sel, rs1: bus.out_rs1, rd: bus.out_rd,
          wen: bus.out_wen, jump: bus.out_jump, ebreak: bus.out_ebreak,
          illegal: bus.out_illegal};
    return a;
  endfunction

  // Monitor/scoreboard: compare at the falling edge, then advance the model
  // with the handshakes that the next rising edge will see.
  always @(negedge clk) begin
    bit can_in;
    if (rst) begin
      q.delete();
      chk("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
      chk("rst_out_data", 128'(act_bundle()), 128'(0));
    end else begin
      can_in = (q.size() < 2);
      chk("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(bus.in_ready), 128'(can_in));
      if (bus.out_valid && q.size() != 0) begin
        chk("head_bundle", 128'(act_bundle()), 128'(q[0]));
        if (bus.out_ready) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (bus.in_valid && can_in) q.push_back(ref_dec(bus.in_inst, bus.in_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk({nm, "_timeout"}, 128'(1'b0), 128'(1'b1));
        break;
      end
    end
    step();
  endtask

  // Single instruction into an empty stage, held one cycle, then drained.
  task automatic dir_dec(input string nm, input logic [31:0] inst,
                         input logic [31:0] pc, input exp_t e);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk(nm, 128'(act_bundle()), 128'(e));
    step();
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[31:7], 7'b0110111};
      1: return {r[31:7], 7'b0010111};
      2: return {r[31:7], 7'b1101111};
      3: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
      4: return {r[31:15], 3'b000, r[11:7], 7'b0010011};
      5: return {r[31:15], 3'b011, r[11:7], 7'b0010011};
      6: return 32'h0010_0073;
      default: return r;
    endcase
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    dir_dec("dec_addi",   32'h0050_0093, 32'h8000_0000,
            mk(32'h8000_0000, 3'd0, 32'h0000_0005, 1'b0, 5'd0,  5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    dir_dec("dec_lui",    32'h1234_5137, 32'h8000_0004,
            mk(32'h8000_0004, 3'd1, 32'h1234_5000, 1'b0, 5'd8,  5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    dir_dec("dec_jal",    32'hFFDF_F0EF, 32'h8000_0008,
            mk(32'h8000_0008, 3'd2, 32'hFFFF_FFFC, 1'b1, 5'd31, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    dir_dec("dec_sltiu",  32'hFFF0_B193, 32'h8000_000C,
            mk(32'h8000_000C, 3'd4, 32'hFFFF_FFFF, 1'b0, 5'd1,  5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    dir_dec("dec_zero",   32'h0000_0000, 32'h8000_0010,
            mk(32'h8000_0010, 3'd0, 32'h0,         1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    dir_dec("dec_ebreak", 32'h0010_0073, 32'h8000_0014,
            mk(32'h8000_0014, 3'd0, 32'h0,         1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Backpressure: A and B fill the buffer, C waits until a drain.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h0050_0093; bus.in_pc = 32'h8000_0100;
    step();
    bus.in_inst   = 32'h1234_5137; bus.in_pc = 32'h8000_0104;
    step();
    bus.in_inst   = 32'hFFF0_B193; bus.in_pc = 32'h8000_0108;
    @(negedge clk);
    chk("bp_in_ready_low", 128'(bus.in_ready), 128'(1'b0));
    step();
    bus.out_ready = 1'b1;
    wait_accept("bp_c_accept");
    bus.in_valid  = 1'b0;
    repeat (4) step();

    // Flush while full with a pending input.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h0050_0093; bus.in_pc = 32'h8000_0200;
    step();
    bus.in_inst   = 32'h1234_5137; bus.in_pc = 32'h8000_0204;
    step();
    bus.in_inst   = 32'hFFDF_F0EF; bus.in_pc = 32'h8000_0208;
    flush         = 1'b1;
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1'b1));
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset between edges while one entry is held.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h0050_0093; bus.in_pc = 32'h8000_0300;
    step();
    bus.in_valid  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("arst_in_ready", 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk);
    #1 rst = 1'b0;
    dir_dec("post_rst_sltiu", 32'hFFF0_B193, 32'h8000_0304,
            mk(32'h8000_0304, 3'd4, 32'hFFFF_FFFF, 1'b0, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));

    // Randomized traffic with occasional flushes.
    repeat (400) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_inst   = rnd_inst();
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 31) == 0);
      step();
    end
    bus.in_valid  = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("final_drained", 128'(bus.out_valid), 128'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/idu_stage.md
# idu_stage

Instruction decode stage of the NPC core. It sits between the fetch unit and the execute unit that holds the ALU. It accepts one raw instruction and its PC per valid/ready handshake and decodes it into the ALU control code, sign-extended immediate, operand select and writeback controls the ALU consumes. A two-entry skid buffer registers the outputs, so no combinational path runs from the execute side's ready back to the fetch side.

## Interface
Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  drops all buffered entries and any same-cycle input.
- in_valid  in  1  fetch offers in_inst/in_pc.
- in_ready  out  XLEN-independent 1  stage can accept; registered.
- in_inst  in  32  raw RV32 instruction.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  PC passed through.
- out_alu_ctrl  out  3  ALU code: 000 add, 001 pass imm, 010 add (jal target), 011 (add)&~1, 100 unsigned less-than.
- out_imm  out  XLEN  sign-extended immediate.
- out_src1_sel  out  1  0 = rs1 value, 1 = PC.
- out_rs1, out_rd  out  5 each  register indices.
- out_wen  out  1  register writeback enable.
- out_jump  out  1  jal/jalr: rd receives pc+4 and the PC is redirected to the ALU result.
- out_ebreak  out  1  ebreak (0x00100073) decoded.
- out_illegal  out  1  unsupported encoding.

## Operation
Supported instructions:
- auipc → ctrl 000, src1_sel 1, U-imm.
- lui → ctrl 001, U-imm.
- jal → ctrl 010, src1_sel 1, J-imm, jump.
- jalr (funct3 000) → ctrl 011, src1_sel 0, I-imm, jump.
- addi → ctrl 000, I-imm.
- sltiu → ctrl 100, I-imm.
- ebreak → all zero except ebreak=1.

Immediate formats:
- I-imm = sext(inst[31:20]).
- U-imm = {inst[31:12], 12'b0}.
- J-imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).

Field and control rules:
- out_wen = 1 for every supported instruction except ebreak.
- out_rs1 and out_rd are always inst[19:15] and inst[11:7].
- Any other encoding is illegal: ctrl 000, imm 0, wen 0, jump 0, illegal 1. The illegal entry still flows through the buffer.

Buffer and handshake:
- Transfer occurs when valid && ready on either side.
- Decode is done at the input, and the decoded bundle is stored in the buffer.
- Buffer states: EMPTY, ONE, FULL.
  - EMPTY + in transfer → ONE.
  - ONE + in only → FULL.
  - ONE + out only → EMPTY.
  - ONE + both → ONE.
  - FULL + out → ONE.
  - FULL never accepts input.
- in_ready = (state != FULL), registered.
- out_valid = (state != EMPTY).
- Outputs always present the oldest entry; order is strictly FIFO.
- flush: next state EMPTY whatever the handshakes. A same-cycle input is discarded; a same-cycle out transfer still counts for the consumer.

## Timing
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 if the buffer was empty.
- Throughput: one instruction per cycle while out_ready is held high.
- in_ready falls in the cycle after the second entry is stored without drain, and rises in the cycle after a drain from FULL.
- Reset values (take effect immediately on rst, asynchronous): state EMPTY, out_valid 0, in_ready 1, all out_* data 0.
- Reset mid-transfer loses both entries and raises no spurious out_valid.
- Output data stays stable while out_valid && !out_ready.

## Structure
- Shared package npc_pkg holds:
  - the opcode constants (OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_JALR 1100111, OP_IMM 0010011);
  - the funct3 constants;
  - INST_EBREAK;
  - the ALU_ADD/ALU_LUI/ALU_JAL/ALU_JALR/ALU_SLTU codes shared with the ALU;
  - the packed decoded-bundle typedef.
- Sub-module idu_decode: pure combinational inst → bundle, instantiated once at the input. The top level holds the skid buffer and state register.

## Test plan
- Decode: addi x1,x0,5 (0x00500093) at pc 0x80000000 → one cycle later ctrl 000, imm 0x00000005, src1_sel 0, rd 1, wen 1.
- Decode: lui x2,0x12345 (0x12345137) → ctrl 001, imm 0x12345000, rd 2. jal ra,-4 (0xFFDFF0EF) → ctrl 010, imm 0xFFFFFFFC, src1_sel 1, jump 1.
- Decode: sltiu x3,x1,-1 (0xFFF0B193) → ctrl 100, imm 0xFFFFFFFF, rs1 1, rd 3. Input 0x00000000 → illegal 1, wen 0. Input 0x00100073 → ebreak 1, wen 0.
- Backpressure: out_ready low, offer A, B, C back-to-back → A and B accepted, in_ready 0 from the cycle after B. Raise out_ready → A, B, C emerge in order with no duplicates.
- Flush while FULL with in_valid high → next cycle out_valid 0, in_ready 1, offered instruction never appears.
- Assert rst asynchronously between clock edges while ONE → out_valid drops before the next edge; after release, the first accepted instruction emerges with correct decode.
